// File: rtl/gray_pkg.sv
// Shared definitions for the Gray step encoder.
//   W            : count / code width (4 bits, 0..15)
//   btn_state_t  : per-button step state (IDLE / ARMED / HELD)
//   bin2gray()   : binary to reflected Gray conversion
package gray_pkg;

   localparam int W = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      HELD  = 2'd2
   } btn_state_t;

   function automatic logic [W-1:0] bin2gray(input logic [W-1:0] b);
      return b ^ (b >> 1);
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// One pushbutton path: 2-FF synchronizer, debounce counter and step FSM.
// Emits a single-cycle step pulse when the debounced level rises; release is
// silent. Build option AUTO_REPEAT_EN adds a repeat step every REPEAT_CYCLES
// of continuous debounced hold.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   btn        : raw asynchronous button, active high
//   step       : one-cycle step request (combinational from FSM state)
module btn_debounce
   import gray_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int REPEAT_CYCLES   = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn,
   output logic step
);

   localparam int            CW      = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] DEB_MAX = CW'(DEBOUNCE_CYCLES);

   logic          sync1, sync2, deb;
   logic [CW-1:0] cnt;
   btn_state_t    state, nstate;
   logic          rpt_fire;

   // Counter tracks how long the synced level has disagreed with the
   // accepted level; any agreement restarts the count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         deb   <= 1'b0;
         cnt   <= '0;
      end else begin
         sync1 <= btn;
         sync2 <= sync1;
         if (sync2 == deb) begin
            cnt <= '0;
         end else if (cnt == DEB_MAX) begin
            deb <= ~deb;
            cnt <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= nstate;
   end

   always_comb begin
      nstate = state;
      step   = 1'b0;
      case (state)
         IDLE: begin
            if (deb) begin
               step   = 1'b1;
               nstate = ARMED;
            end
         end
         ARMED, HELD: begin
            if (!deb) begin
               nstate = IDLE;
            end else if (rpt_fire) begin
               step   = 1'b1;
               nstate = HELD;
            end
         end
         default: nstate = IDLE;
      endcase
   end

`ifdef AUTO_REPEAT_EN
   localparam int            RW      = $clog2(REPEAT_CYCLES + 1);
   localparam logic [RW-1:0] RPT_MAX = RW'(REPEAT_CYCLES - 1);

   logic [RW-1:0] rpt;

   // Hold timer runs only while armed and held; a fire restarts it so the
   // spacing between repeat steps is exactly REPEAT_CYCLES.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                        rpt <= '0;
      else if (state == IDLE || !deb)    rpt <= '0;
      else if (rpt == RPT_MAX)           rpt <= '0;
      else                               rpt <= rpt + 1'b1;
   end

   assign rpt_fire = deb && (state != IDLE) && (rpt == RPT_MAX);
`else
   // Repeat disabled: the hold time is irrelevant and this folds to 0.
   assign rpt_fire = (REPEAT_CYCLES < 0);
`endif

endmodule

// File: rtl/gray_step_enc.sv
// Gray step encoder: pushbuttons step a 4-bit count up/down (mod 16), a
// binary load from switches overrides stepping, and the count is presented
// both as binary and as Gray code from the same register edge.
// Optional macro: AUTO_REPEAT_EN (auto-repeat while a button is held).
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   btn_up, btn_down    : raw bouncy buttons, active high
//   load, bin_in[3:0]   : synchronous binary load (load has priority)
//   gray_out[3:0]       : registered Gray code of the count
//   bin_out[3:0]        : registered binary count
//   strb                : one-cycle pulse when the outputs took a new value
//   wrap                : one-cycle pulse with strb on a 15->0 / 0->15 step
module gray_step_enc
   import gray_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int REPEAT_CYCLES   = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         btn_up,
   input  logic         btn_down,
   input  logic         load,
   input  logic [W-1:0] bin_in,
   output logic [W-1:0] gray_out,
   output logic [W-1:0] bin_out,
   output logic         strb,
   output logic         wrap
);

   logic         step_up, step_dn;
   logic [W-1:0] nxt;
   logic         chg, wr;

   btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_CYCLES   (REPEAT_CYCLES)
   ) u_up (
      .clk   (clk),
      .rst_n (rst_n),
      .btn   (btn_up),
      .step  (step_up)
   );

   btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_CYCLES   (REPEAT_CYCLES)
   ) u_dn (
      .clk   (clk),
      .rst_n (rst_n),
      .btn   (btn_down),
      .step  (step_dn)
   );

   // Load beats stepping; simultaneous up and down steps cancel.
   always_comb begin
      nxt = bin_out;
      chg = 1'b0;
      wr  = 1'b0;
      if (load) begin
         nxt = bin_in;
         chg = (bin_in != bin_out);
      end else if (step_up && !step_dn) begin
         nxt = bin_out + 1'b1;
         chg = 1'b1;
         wr  = (bin_out == '1);
      end else if (step_dn && !step_up) begin
         nxt = bin_out - 1'b1;
         chg = 1'b1;
         wr  = (bin_out == '0);
      end
   end

   // Gray is encoded from the next count so both views change on one edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bin_out  <= '0;
         gray_out <= '0;
         strb     <= 1'b0;
         wrap     <= 1'b0;
      end else begin
         bin_out  <= nxt;
         gray_out <= bin2gray(nxt);
         strb     <= chg;
         wrap     <= wr;
      end
   end

endmodule

// File: tb/tb_gray_step_enc.sv
module tb_gray_step_enc;

   localparam int DEB = 4;
   localparam int RPT = 8;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       btn_up = 1'b0, btn_down = 1'b0, load = 1'b0;
   logic [3:0] bin_in = 4'd0;
   logic [3:0] gray_out, bin_out;
   logic       strb, wrap;

   always #5 clk = ~clk;

   gray_step_enc #(.DEBOUNCE_CYCLES(DEB), .REPEAT_CYCLES(RPT)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .btn_up   (btn_up),
      .btn_down (btn_down),
      .load     (load),
      .bin_in   (bin_in),
      .gray_out (gray_out),
      .bin_out  (bin_out),
      .strb     (strb),
      .wrap     (wrap)
   );

   typedef struct {
      int bin;
      int gray;
      bit wrp;
   } exp_t;

   exp_t sbq[$];
   int   n_cmp = 0, n_err = 0;
   bit   running = 1'b1;

   // Reference model: a button is accepted once its raw level (seen through a
   // two-sample delay) has disagreed with the accepted level for DEB+1 edges
   // in a row; the step lands one edge later.
   int   gtab[16];
   int   m_cnt;
   bit   exp_strb;
   bit   hist[2][0:DEB+2];
   bit   deb[2], pend[2];
   int   rep[2];
   int   edge_n;

   task automatic chk(input string nm, input int act, input int expv);
      n_cmp++;
      if (act != expv) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
      end
   endtask

   task automatic model_reset();
      m_cnt = 0;
      exp_strb = 1'b0;
      edge_n = 0;
      for (int b = 0; b < 2; b++) begin
         deb[b] = 1'b0;
         pend[b] = 1'b0;
         rep[b] = -1;
         for (int i = 0; i <= DEB + 2; i++) hist[b][i] = 1'b0;
      end
      sbq.delete();
   endtask

   task automatic push_exp(input bit w);
      exp_t e;
      e.bin = m_cnt;
      e.gray = gtab[m_cnt];
      e.wrp = w;
      sbq.push_back(e);
      exp_strb = 1'b1;
   endtask

   task automatic model_edge(input bit r_up, input bit r_dn, input bit ld, input int bi);
      bit stp[2];
      bit r, all_diff;
      for (int b = 0; b < 2; b++) begin
         stp[b] = pend[b];
`ifdef AUTO_REPEAT_EN
         if (deb[b] && rep[b] == edge_n) begin
            stp[b] = 1'b1;
            rep[b] += RPT;
         end
`endif
      end
      exp_strb = 1'b0;
      if (ld) begin
         if (bi != m_cnt) begin
            m_cnt = bi;
            push_exp(1'b0);
         end
      end else if (stp[0] && !stp[1]) begin
         push_exp(1'b0);
         sbq[$].wrp = (m_cnt == 15);
         m_cnt = (m_cnt + 1) % 16;
         sbq[$].bin = m_cnt;
         sbq[$].gray = gtab[m_cnt];
      end else if (stp[1] && !stp[0]) begin
         push_exp(1'b0);
         sbq[$].wrp = (m_cnt == 0);
         m_cnt = (m_cnt + 15) % 16;
         sbq[$].bin = m_cnt;
         sbq[$].gray = gtab[m_cnt];
      end
      for (int b = 0; b < 2; b++) begin
         r = (b == 0) ? r_up : r_dn;
         for (int i = 0; i < DEB + 2; i++) hist[b][i] = hist[b][i+1];
         hist[b][DEB+2] = r;
         all_diff = 1'b1;
         for (int i = 0; i <= DEB; i++) if (hist[b][i] == deb[b]) all_diff = 1'b0;
         pend[b] = 1'b0;
         if (all_diff) begin
            deb[b] = ~deb[b];
            if (deb[b]) begin
               pend[b] = 1'b1;
               rep[b] = edge_n + 1 + RPT;
            end
         end
      end
      edge_n++;
   endtask

   // Drive one cycle of inputs on the falling edge and advance the model.
   task automatic cyc(input bit u, input bit d, input bit ld, input int bi);
      @(negedge clk);
      btn_up = u;
      btn_down = d;
      load = ld;
      bin_in = 4'(bi);
      if (rst_n) model_edge(u, d, ld, bi);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 0);
   endtask

   task automatic hold(input bit u, input bit d, input int n);
      for (int i = 0; i < n; i++) cyc(u, d, 1'b0, 0);
   endtask

   // Reset asserted between edges: outputs must clear without a clock.
   task automatic do_reset(input int n);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      btn_up = 1'b0;
      btn_down = 1'b0;
      load = 1'b0;
      #1;
      chk("rst_async", {bin_out, gray_out, strb, wrap}, 0);
      model_reset();
      repeat (n) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      model_edge(btn_up, btn_down, load, int'(bin_in));
   endtask

   // Monitor: every cycle the registered outputs are compared; a strobe pops
   // the next expected transaction.
   always @(posedge clk) begin
      #1;
      if (running) begin
         chk("strb", strb, exp_strb);
         if (strb) begin
            if (sbq.size() == 0) begin
               chk("sb_empty_on_strb", 1, 0);
            end else begin
               exp_t e;
               e = sbq.pop_front();
               chk("bin_out", bin_out, e.bin);
               chk("gray_out", gray_out, e.gray);
               chk("wrap", wrap, e.wrp);
            end
         end else begin
            chk("wrap_idle", wrap, 0);
            chk("bin_hold", bin_out, m_cnt);
            chk("gray_hold", gray_out, gtab[m_cnt]);
         end
      end
   end

   initial begin
      // Reflected Gray table built by mirror-and-prefix.
      gtab[0] = 0;
      gtab[1] = 1;
      for (int b = 1; b < 4; b++)
         for (int i = 0; i < (1 << b); i++)
            gtab[(1 << (b + 1)) - 1 - i] = gtab[i] | (1 << b);

      model_reset();
      do_reset(3);
      idle(3);

      // load 9 twice: second one must not strobe
      cyc(1'b0, 1'b0, 1'b1, 9);
      idle(2);
      chk("load9_gray", gray_out, 4'b1101);
      cyc(1'b0, 1'b0, 1'b1, 9);
      idle(2);

      // clean press from 9 held 20 cycles
      hold(1'b1, 1'b0, 20);
      idle(10);
      chk("press_bin", bin_out, 10);
      chk("press_gray", gray_out, 4'b1111);

      // bounce then a stable press
      for (int k = 0; k < 2; k++) begin
         hold(1'b1, 1'b0, 2);
         hold(1'b0, 1'b0, 2);
      end
      hold(1'b1, 1'b0, 12);
      idle(10);

      // bounce then reset while the press is still debouncing
      for (int k = 0; k < 2; k++) begin
         hold(1'b1, 1'b0, 2);
         hold(1'b0, 1'b0, 2);
      end
      hold(1'b1, 1'b0, 3);
      do_reset(2);
      idle(12);

      // wrap down from 0, then wrap up from 15
      hold(1'b1, 1'b1, 1);
      hold(1'b0, 1'b1, 10);
      idle(10);
      chk("wrap_dn_gray", gray_out, 4'b1000);
      hold(1'b1, 1'b0, 10);
      idle(10);

      // simultaneous presses cancel
      cyc(1'b0, 1'b0, 1'b1, 6);
      hold(1'b1, 1'b1, 12);
      idle(10);

      // load collides with an up step
      for (int i = 0; i < 20; i++) begin
         if (pend[0]) cyc(1'b1, 1'b0, 1'b1, 3);
         else         cyc(1'b1, 1'b0, 1'b0, 0);
      end
      idle(10);
      chk("load_vs_step", bin_out, 3);

      // long hold from 0 (repeats only with AUTO_REPEAT_EN)
      cyc(1'b0, 1'b0, 1'b1, 0);
      hold(1'b1, 1'b0, 40);
      idle(10);

      // randomized buttons, loads and occasional resets
      for (int s = 0; s < 200; s++) begin
         bit u, d;
         int len;
         u = ($urandom_range(2, 0) == 0);
         d = ($urandom_range(2, 0) == 0);
         len = $urandom_range(25, 1);
         if ($urandom_range(39, 0) == 0) do_reset($urandom_range(3, 1));
         for (int i = 0; i < len; i++)
            cyc(u, d, ($urandom_range(11, 0) == 0), $urandom_range(15, 0));
      end
      idle(30);

      chk("sb_drained", sbq.size(), 0);
      running = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got no end expected end");
      $fatal(1);
   end

endmodule
